// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says game controller.
// Colour codes double as the sequence-memory data word.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [3:0] {
    IDLE, CLEAR, GEN_REQ, GEN_WAIT, SHOW_ON, SHOW_OFF, INPUT, CHK_WAIT, WIN, LOSE
  } game_state_t;

  localparam int MEM_DEPTH = 16;

  // x^8+x^6+x^5+x^4+1 as left-shift Fibonacci: feedback from b7,b5,b4,b3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    onehot = 4'b0001 << c;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    lfsr_next = {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit colour-sequence LFSR; load wins over step so a replay can restart
// from the game seed in the same cycle the last colour is consumed.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] value_q;

  always_ff @(posedge clk) begin
    if (load)      value_q <= seed;
    else if (step) value_q <= lfsr_next(value_q);
  end

  assign value = value_q;

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says game controller: fills the sequence memory from an LFSR, replays
// it on the LEDs, then pops and compares one entry per player press.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned DISPLAY_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned MAX_LEN        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] color_btn,
  output logic       mem_mode,
  output logic       mem_req,
  output logic       mem_clear,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  input  logic       mem_ack,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic [3:0] led,
  output logic [4:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  game_state_t state_q, state_d;
  logic [7:0]  seed_cnt_q, game_seed_q, game_seed_d;
  logic [4:0]  round_q, round_d, idx_q, idx_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  btn_q, btn_d;
  color_t      exp_q, exp_d;
  logic        win_q, win_d, lose_q, lose_d;

  logic [3:0]  led_q, led_d;
  logic        mem_req_q, mem_req_d, mem_mode_q, mem_mode_d;
  logic        mem_clear_q, mem_clear_d, busy_q, busy_d;
  logic [1:0]  mem_wdata_q, mem_wdata_d;

  logic        lfsr_load, lfsr_step;
  logic [7:0]  lfsr_val;
  logic [1:0]  peek_col;

  simon_lfsr u_lfsr (
    .clk   (clk),
    .load  (lfsr_load),
    .seed  (game_seed_q),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  // Colour the LFSR will hold next cycle, so registered outputs line up with state
  assign peek_col = lfsr_load ? game_seed_q[1:0] :
                    lfsr_step ? {lfsr_val[0], ^(lfsr_val & LFSR_TAPS)} :
                                lfsr_val[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      seed_cnt_q  <= '0;
      game_seed_q <= 8'h01;
      round_q     <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      btn_q       <= '0;
      exp_q       <= RED;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      led_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_mode_q  <= 1'b0;
      mem_clear_q <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_q + 8'd1;
      game_seed_q <= game_seed_d;
      round_q     <= round_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      btn_q       <= btn_d;
      exp_q       <= exp_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      led_q       <= led_d;
      mem_req_q   <= mem_req_d;
      mem_mode_q  <= mem_mode_d;
      mem_clear_q <= mem_clear_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    game_seed_d = game_seed_q;
    round_d     = round_q;
    idx_d       = idx_q;
    btn_d       = btn_q;
    exp_d       = exp_q;
    win_d       = win_q;
    lose_d      = lose_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    timer_d     = timer_q + 32'd1;
    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          game_seed_d = (seed_cnt_q == 8'h00) ? 8'h01 : seed_cnt_q;
          round_d     = 5'd1;
          win_d       = 1'b0;
          lose_d      = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        lfsr_load = 1'b1;
        idx_d     = '0;
        state_d   = GEN_REQ;
      end
      GEN_REQ: state_d = GEN_WAIT;
      GEN_WAIT: begin
        if (mem_ack) begin
          lfsr_step = 1'b1;
          idx_d     = idx_q + 5'd1;
          if (idx_q + 5'd1 == round_q) begin
            lfsr_load = 1'b1;
            idx_d     = '0;
            state_d   = SHOW_ON;
          end else begin
            state_d   = GEN_REQ;
          end
        end
      end
      SHOW_ON: begin
        if (timer_q == 32'(DISPLAY_CYCLES - 1)) begin
          lfsr_step = 1'b1;
          idx_d     = idx_q + 5'd1;
          state_d   = SHOW_OFF;
        end
      end
      SHOW_OFF: begin
        if (timer_q == 32'(GAP_CYCLES - 1))
          state_d = (idx_q == round_q) ? INPUT : SHOW_ON;
      end
      INPUT: begin
        if (color_btn != 4'b0000) begin
          btn_d   = color_btn;
          exp_d   = color_t'(mem_rdata);
          state_d = CHK_WAIT;
        end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
          lose_d  = 1'b1;
          state_d = LOSE;
        end
      end
      CHK_WAIT: begin
        // a multi-bit press can never equal a one-hot colour, so it loses here
        if (mem_ack) begin
          if (btn_q != onehot(exp_q)) begin
            lose_d  = 1'b1;
            state_d = LOSE;
          end else if (!fifo_empty) begin
            state_d = INPUT;
          end else if (round_q == 5'(MAX_LEN)) begin
            win_d   = 1'b1;
            state_d = WIN;
          end else begin
            round_d = round_q + 5'd1;
            state_d = CLEAR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state they belong to.
  always_comb begin
    led_d       = 4'b0000;
    if (state_d == SHOW_ON)  led_d = onehot(peek_col);
    else if (state_d == WIN) led_d = 4'b1111;
    mem_mode_d  = (state_d inside {GEN_REQ, GEN_WAIT});
    mem_req_d   = (state_d == GEN_REQ && !fifo_full) ||
                  (state_q == INPUT && state_d == CHK_WAIT && !fifo_empty);
    mem_clear_d = (state_d == CLEAR);
    mem_wdata_d = (state_d == GEN_REQ) ? peek_col : mem_wdata_q;
    busy_d      = !(state_d inside {IDLE, WIN, LOSE});
  end

  assign led       = led_q;
  assign mem_req   = mem_req_q;
  assign mem_mode  = mem_mode_q;
  assign mem_clear = mem_clear_q;
  assign mem_wdata = mem_wdata_q;
  assign round     = round_q;
  assign busy      = busy_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Bench for simon_game_ctrl with a behavioural sequence-memory FSM and RAM;
// seed 8'h0A gives the colour sequence BLUE, GREEN, YELLOW.
module tb_simon_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] color_btn = 4'b0000;
  logic       mem_mode, mem_req, mem_clear;
  logic [1:0] mem_wdata, mem_rdata;
  logic       mem_ack, fifo_full, fifo_empty;
  logic [3:0] led;
  logic [4:0] round;
  logic       busy, win, lose;

  always #5 clk = ~clk;

  simon_game_ctrl #(
    .DISPLAY_CYCLES (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (40),
    .MAX_LEN        (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .color_btn  (color_btn),
    .mem_mode   (mem_mode),
    .mem_req    (mem_req),
    .mem_clear  (mem_clear),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .led        (led),
    .round      (round),
    .busy       (busy),
    .win        (win),
    .lose       (lose)
  );

  // Sequence memory: request registered, operation one cycle later, ack with it
  logic [1:0] ram [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  logic       p1_vld, p1_mode, ack_q;
  logic [1:0] p1_data;

  assign fifo_full  = (cnt == 5'd16);
  assign fifo_empty = (cnt == 5'd0);
  assign mem_rdata  = ram[rp];
  assign mem_ack    = ack_q;

  always @(posedge clk) begin
    if (reset || mem_clear) begin
      wp <= '0; rp <= '0; cnt <= '0; p1_vld <= 1'b0; ack_q <= 1'b0;
    end else begin
      p1_vld  <= mem_req;
      p1_mode <= mem_mode;
      p1_data <= mem_wdata;
      ack_q   <= 1'b0;
      if (p1_vld) begin
        if (p1_mode && !fifo_full) begin
          ram[wp] <= p1_data; wp <= wp + 4'd1; cnt <= cnt + 5'd1; ack_q <= 1'b1;
        end else if (!p1_mode && !fifo_empty) begin
          rp <= rp + 4'd1; cnt <= cnt - 5'd1; ack_q <= 1'b1;
        end
      end
    end
  end

  // Write log per round, and the request-while-full/empty guard
  logic [1:0] wr_seq [16];
  int         wr_cnt = 0;
  int         viol = 0;

  always @(posedge clk) begin
    if (reset || mem_clear) wr_cnt <= 0;
    else if (mem_req && mem_mode) begin
      wr_seq[wr_cnt[3:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (!reset && mem_req && (mem_mode ? fifo_full : fifo_empty)) viol <= viol + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_game();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  // Reset, release, start after 10 cycles so the seed is 8'h0A
  task automatic reset_and_start();
    reset = 1'b1; tick(3); reset = 1'b0; tick(10); start_game();
  endtask

  typedef struct {
    int         wait_cyc;
    logic [3:0] btn;
    int         wlen;
    logic [4:0] exp_round;
    logic       exp_win;
    logic       exp_lose;
    logic       exp_busy;
    logic [3:0] exp_led;
  } vec_t;

  vec_t       vecs [9];
  logic [1:0] exp_seq [3];

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick(vecs[i].wait_cyc);
      if (vecs[i].wlen != 0) begin
        chk("write_count", wr_cnt, vecs[i].wlen);
        for (int j = 0; j < vecs[i].wlen; j++) chk("write_seq", wr_seq[j], exp_seq[j]);
      end
      color_btn = vecs[i].btn; tick(1); color_btn = 4'b0000; tick(2);
      chk("chk_wait_lose", lose, 1'b0);
      chk("chk_wait_busy", busy, 1'b1);
      tick(1);
      chk("vec_round", round, vecs[i].exp_round);
      chk("vec_win",   win,   vecs[i].exp_win);
      chk("vec_lose",  lose,  vecs[i].exp_lose);
      chk("vec_busy",  busy,  vecs[i].exp_busy);
      chk("vec_led",   led,   vecs[i].exp_led);
    end
  endtask

  initial begin
    exp_seq[0] = 2'd2; exp_seq[1] = 2'd1; exp_seq[2] = 2'd3;
    // winning game, continuing from round-1 INPUT
    vecs[0] = '{0,  4'b0100, 1, 5'd2, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[1] = '{19, 4'b0100, 2, 5'd2, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[2] = '{0,  4'b0010, 0, 5'd3, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[3] = '{28, 4'b0100, 3, 5'd3, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[4] = '{0,  4'b0010, 0, 5'd3, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[5] = '{0,  4'b1000, 0, 5'd3, 1'b1, 1'b0, 1'b0, 4'b1111};
    // wrong colour on second press of round 2
    vecs[6] = '{0,  4'b0100, 1, 5'd2, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[7] = '{19, 4'b0100, 2, 5'd2, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[8] = '{0,  4'b0001, 0, 5'd2, 1'b0, 1'b1, 1'b0, 4'b0000};

    // reset state
    tick(3);
    chk("rst_led", led, 4'b0000);       chk("rst_req", mem_req, 1'b0);
    chk("rst_mode", mem_mode, 1'b0);    chk("rst_clear", mem_clear, 1'b0);
    chk("rst_wdata", mem_wdata, 2'b00); chk("rst_round", round, 5'd0);
    chk("rst_busy", busy, 1'b0);        chk("rst_win", win, 1'b0);
    chk("rst_lose", lose, 1'b0);

    // game 1: first write and display, then win through the table
    reset = 1'b0; tick(10); start_game();
    chk("g1_clear", mem_clear, 1'b1); chk("g1_busy", busy, 1'b1);
    chk("g1_round", round, 5'd1);     chk("g1_req_idle", mem_req, 1'b0);
    tick(1);
    chk("g1_req", mem_req, 1'b1);     chk("g1_mode", mem_mode, 1'b1);
    chk("g1_wdata", mem_wdata, 2'b10); chk("g1_clear_off", mem_clear, 1'b0);
    tick(1);
    chk("g1_req_pulse", mem_req, 1'b0); chk("g1_mode_hold", mem_mode, 1'b1);
    tick(2);
    for (int k = 0; k < 4; k++) begin chk("g1_led_on", led, 4'b0100); tick(1); end
    chk("g1_led_gap", led, 4'b0000);
    tick(2);
    run_vecs(0, 5);

    // game 2: wrong colour
    reset_and_start(); tick(10);
    run_vecs(6, 8);

    // game 3: timeout, then restart clears lose
    reset_and_start(); tick(10);
    tick(39);
    chk("to_not_yet", lose, 1'b0);
    tick(1);
    chk("to_lose", lose, 1'b1); chk("to_busy", busy, 1'b0); chk("to_led", led, 4'b0000);
    tick(5); start_game();
    chk("restart_lose", lose, 1'b0); chk("restart_round", round, 5'd1);
    chk("restart_busy", busy, 1'b1);

    // game 4: out-of-phase presses ignored, multi-bit press loses
    reset_and_start(); tick(5);
    color_btn = 4'b0010; tick(1); color_btn = 4'b0000;
    chk("show_press_led", led, 4'b0100); chk("show_press_req", mem_req, 1'b0);
    tick(4);
    color_btn = 4'b0100; tick(1); color_btn = 4'b0000; tick(1);
    color_btn = 4'b0001; tick(1); color_btn = 4'b0000; tick(1);
    chk("chk_press_round", round, 5'd2); chk("chk_press_lose", lose, 1'b0);
    chk("chk_press_busy", busy, 1'b1);
    tick(19);
    color_btn = 4'b0011; tick(1); color_btn = 4'b0000; tick(3);
    chk("multi_lose", lose, 1'b1); chk("multi_busy", busy, 1'b0);

    // game 5: reset during GEN_WAIT
    reset_and_start(); tick(2);
    reset = 1'b1; tick(1);
    chk("mid_led", led, 4'b0000);       chk("mid_req", mem_req, 1'b0);
    chk("mid_mode", mem_mode, 1'b0);    chk("mid_clear", mem_clear, 1'b0);
    chk("mid_wdata", mem_wdata, 2'b00); chk("mid_round", round, 5'd0);
    chk("mid_busy", busy, 1'b0);        chk("mid_win", win, 1'b0);
    chk("mid_lose", lose, 1'b0);        chk("mid_empty", fifo_empty, 1'b1);
    reset = 1'b0; tick(2);

    chk("req_guard", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
